// File: rtl/spi_sensor_arbiter_if.sv
// Requester-side bus of the sensor SPI arbiter.
// Polling logic drives requests/data; the arbiter returns grants and bytes.
interface spi_sensor_arbiter_if;
  logic [2:0] REQ;
  logic [3:0] LEN0;
  logic [3:0] LEN1;
  logic [3:0] LEN2;
  logic [7:0] TX_DATA0;
  logic [7:0] TX_DATA1;
  logic [7:0] TX_DATA2;
  logic [2:0] GNT;
  logic [2:0] TX_POP;
  logic [7:0] RX_DATA;
  logic [2:0] RX_VALID;
  logic [2:0] DONE;

  modport master (
    output REQ, LEN0, LEN1, LEN2,
    output TX_DATA0, TX_DATA1, TX_DATA2,
    input  GNT, TX_POP, RX_DATA,
    input  RX_VALID, DONE
  );

  modport slave (
    input  REQ, LEN0, LEN1, LEN2,
    input  TX_DATA0, TX_DATA1, TX_DATA2,
    output GNT, TX_POP, RX_DATA,
    output RX_VALID, DONE
  );
endinterface

// File: rtl/spi_sensor_arbiter.sv
// Round-robin SPI mode-3 master shared by three sensor requesters.
// Requester side on the interface, board SPI pins as plain ports.
module spi_sensor_arbiter #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic CLOCK,
  input  logic RESET_N,
  spi_sensor_arbiter_if.slave bus,
  output logic CS_AG,
  output logic CS_M,
  output logic CS_ALT,
  output logic SCK,
  output logic SDI,
  input  logic SDO
);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DIV_LAST =
    CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [4:0] left_q, left_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_q, rx_d;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] cs_n_q, cs_n_d;
  logic [2:0] pop_q, pop_d;
  logic [2:0] rxv_q, rxv_d;
  logic [2:0] done_q, done_d;
  logic sck_q, sck_d;
  logic sdi_q, sdi_d;

  logic [5:0] req2, pick6;
  logic [2:0] rot, first, pick, sel;
  logic [7:0] tx_sel;
  logic [3:0] len_sel;
  logic [1:0] ptr_nxt;

  // Rotate REQ so the pointer slot is bit 0, pick, rotate back.
  always_comb begin
    req2  = {bus.REQ, bus.REQ};
    rot   = req2[ptr_q +: 3];
    first = rot[0] ? 3'b001 :
            rot[1] ? 3'b010 :
            rot[2] ? 3'b100 : 3'b000;
    pick6 = {3'b000, first} << ptr_q;
    pick  = pick6[2:0] | pick6[5:3];
  end

  assign sel = (state_q == IDLE) ? pick : gnt_q;

  always_comb begin
    tx_sel  = 8'h00;
    len_sel = 4'h0;
    ptr_nxt = ptr_q;
    unique case (1'b1)
      sel[0]: begin
        tx_sel  = bus.TX_DATA0;
        len_sel = bus.LEN0;
      end
      sel[1]: begin
        tx_sel  = bus.TX_DATA1;
        len_sel = bus.LEN1;
      end
      sel[2]: begin
        tx_sel  = bus.TX_DATA2;
        len_sel = bus.LEN2;
      end
      default: ;
    endcase
    unique case (1'b1)
      gnt_q[0]: ptr_nxt = 2'd1;
      gnt_q[1]: ptr_nxt = 2'd2;
      gnt_q[2]: ptr_nxt = 2'd0;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    left_d  = left_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    sdi_d   = sdi_q;
    pop_d   = 3'b000;
    rxv_d   = 3'b000;
    done_d  = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (pick != 3'b000) begin
          gnt_d   = pick;
          cs_n_d  = ~pick;
          left_d  = {len_sel == 4'd0, len_sel};
          pop_d   = pick;
          shreg_d = tx_sel;
          sdi_d   = tx_sel[7];
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sck_d   = 1'b0;
          sdi_d   = shreg_q[7];
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d   = 1'b1;
            shreg_d = {shreg_q[6:0], SDO};
          end else if (bit_q != 3'd7) begin
            bit_d = bit_q + 3'd1;
            sck_d = 1'b0;
            sdi_d = shreg_q[7];
          end else begin
            // Byte boundary doubles as next byte's first low cycle.
            bit_d = 3'd0;
            rx_d  = shreg_q;
            rxv_d = gnt_q;
            if (left_q > 5'd1) begin
              left_d  = left_q - 5'd1;
              pop_d   = gnt_q;
              shreg_d = tx_sel;
              sdi_d   = tx_sel[7];
              sck_d   = 1'b0;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 3'b111;
          done_d  = gnt_q;
          gnt_d   = 3'b000;
          ptr_d   = ptr_nxt;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      left_q  <= 5'd0;
      shreg_q <= 8'h00;
      rx_q    <= 8'h00;
      ptr_q   <= 2'd0;
      gnt_q   <= 3'b000;
      cs_n_q  <= 3'b111;
      pop_q   <= 3'b000;
      rxv_q   <= 3'b000;
      done_q  <= 3'b000;
      sck_q   <= 1'b1;
      sdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      left_q  <= left_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cs_n_q  <= cs_n_d;
      pop_q   <= pop_d;
      rxv_q   <= rxv_d;
      done_q  <= done_d;
      sck_q   <= sck_d;
      sdi_q   <= sdi_d;
    end
  end

  assign bus.GNT      = gnt_q;
  assign bus.TX_POP   = pop_q;
  assign bus.RX_DATA  = rx_q;
  assign bus.RX_VALID = rxv_q;
  assign bus.DONE     = done_q;
  assign CS_AG        = cs_n_q[0];
  assign CS_M         = cs_n_q[1];
  assign CS_ALT       = cs_n_q[2];
  assign SCK          = sck_q;
  assign SDI          = sdi_q;
endmodule

// File: tb/tb_spi_sensor_arbiter.sv
// Scoreboard bench for spi_sensor_arbiter.
// Expected bytes/DONEs are queued at stimulus time and popped by monitors.
module tb_spi_sensor_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_sensor_arbiter_if bus_a();
  spi_sensor_arbiter_if bus_b();

  logic cs_ag_a, cs_m_a, cs_alt_a;
  logic sck_a, sdi_a, sdo_a, sdo_one;
  logic cs_ag_b, cs_m_b, cs_alt_b;
  logic sck_b, sdi_b, sdo_b;

  assign sdo_a = sdo_one ? 1'b1 : sdi_a;
  assign sdo_b = sdi_b;

  spi_sensor_arbiter #(
    .CLK_DIV(4), .GAP_CYCLES(8)
  ) u_dut (
    .CLOCK(clk), .RESET_N(rst_n), .bus(bus_a),
    .CS_AG(cs_ag_a), .CS_M(cs_m_a),
    .CS_ALT(cs_alt_a), .SCK(sck_a),
    .SDI(sdi_a), .SDO(sdo_a)
  );

  spi_sensor_arbiter #(
    .CLK_DIV(1), .GAP_CYCLES(8)
  ) u_dut1 (
    .CLOCK(clk), .RESET_N(rst_n), .bus(bus_b),
    .CS_AG(cs_ag_b), .CS_M(cs_m_b),
    .CS_ALT(cs_alt_b), .SCK(sck_b),
    .SDI(sdi_b), .SDO(sdo_b)
  );

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } rx_t;

  rx_t        exp_rx[$];
  logic [1:0] exp_done[$];
  rx_t        exp_b[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  int rx_cnt[3];
  int pop_cnt[3];
  int cs_len[3];
  int cs_last[3];
  int done_cnt = 0;
  int sck_falls = 0;
  int multi_low = 0;
  int hi_cnt = 0;
  int gap_log[$];
  logic [2:0] gnt_log[$];
  logic [7:0] sdi_cap = 8'h00;
  logic prev_sck = 1'b1;
  logic [2:0] prev_gnt = 3'b000;
  logic [2:0] cs_a;
  rx_t ea;
  logic [1:0] ed;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_cnt[i] = 0; pop_cnt[i] = 0;
      cs_len[i] = 0; cs_last[i] = 0;
    end
  end

  always @(negedge clk) begin
    cs_a = {cs_alt_a, cs_m_a, cs_ag_a};
    for (int i = 0; i < 3; i++) begin
      if (bus_a.TX_POP[i]) pop_cnt[i]++;
      if (bus_a.RX_VALID[i]) rx_cnt[i]++;
      if (!cs_a[i]) cs_len[i]++;
      else if (cs_len[i] != 0) begin
        cs_last[i] = cs_len[i];
        cs_len[i] = 0;
      end
    end
    if ($countones(~cs_a) > 1) multi_low++;
    if (cs_a == 3'b111) hi_cnt++;
    else if (hi_cnt != 0) begin
      gap_log.push_back(hi_cnt);
      hi_cnt = 0;
    end
    if (prev_sck && !sck_a) sck_falls++;
    if (!prev_sck && sck_a)
      sdi_cap = {sdi_cap[6:0], sdi_a};
    prev_sck = sck_a;
    if (prev_gnt == 3'b000 && bus_a.GNT != 3'b000)
      gnt_log.push_back(bus_a.GNT);
    prev_gnt = bus_a.GNT;
    if (bus_a.RX_VALID != 3'b000) begin
      if (exp_rx.size() == 0)
        chk("rx_unexpected", bus_a.RX_VALID, 0);
      else begin
        ea = exp_rx.pop_front();
        chk("rx_idx", bus_a.RX_VALID,
            32'(3'b001 << ea.idx));
        chk("rx_data", bus_a.RX_DATA, ea.data);
      end
    end
    if (bus_a.DONE != 3'b000) begin
      done_cnt++;
      if (exp_done.size() == 0)
        chk("done_unexpected", bus_a.DONE, 0);
      else begin
        ed = exp_done.pop_front();
        chk("done_idx", bus_a.DONE,
            32'(3'b001 << ed));
      end
    end
  end

  int b_len = 0;
  int b_last = 0;
  int b_cyc = 0;
  int b_per = 0;
  int b_rx = 0;
  int b_done = 0;
  logic b_seen = 1'b0;
  logic b_prev = 1'b1;
  rx_t eb;

  always @(negedge clk) begin
    if (!cs_ag_b) b_len++;
    else if (b_len != 0) begin
      b_last = b_len;
      b_len = 0;
    end
    if (!b_prev && sck_b) begin
      if (b_seen) b_per = b_cyc;
      b_cyc = 0;
      b_seen = 1'b1;
    end
    b_cyc++;
    b_prev = sck_b;
    if (bus_b.DONE != 3'b000) b_done++;
    if (bus_b.RX_VALID != 3'b000) begin
      b_rx++;
      if (exp_b.size() == 0)
        chk("b_rx_unexpected", bus_b.RX_VALID, 0);
      else begin
        eb = exp_b.pop_front();
        chk("b_rx_idx", bus_b.RX_VALID,
            32'(3'b001 << eb.idx));
        chk("b_rx_data", bus_b.RX_DATA, eb.data);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus_a.REQ = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_done_a(input int target,
                             input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target)
      chk("timeout_done", done_cnt, target);
    #1;
  endtask

  int d0, p0, f0, r0, g0, gl0, n, mn;

  initial begin
    sdo_one = 1'b0;
    bus_a.REQ = 3'b000;
    bus_a.LEN0 = 4'd0; bus_a.LEN1 = 4'd0;
    bus_a.LEN2 = 4'd0;
    bus_a.TX_DATA0 = 8'h00; bus_a.TX_DATA1 = 8'h00;
    bus_a.TX_DATA2 = 8'h00;
    bus_b.REQ = 3'b000;
    bus_b.LEN0 = 4'd0; bus_b.LEN1 = 4'd0;
    bus_b.LEN2 = 4'd0;
    bus_b.TX_DATA0 = 8'h00; bus_b.TX_DATA1 = 8'h00;
    bus_b.TX_DATA2 = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_gnt", bus_a.GNT, 0);
    chk("rst_pop", bus_a.TX_POP, 0);
    chk("rst_rxv", bus_a.RX_VALID, 0);
    chk("rst_done", bus_a.DONE, 0);
    chk("rst_rxd", bus_a.RX_DATA, 0);
    chk("rst_sdi", sdi_a, 0);
    chk("rst_cs", {cs_alt_a, cs_m_a, cs_ag_a}, 3'b111);
    chk("rst_sck", sck_a, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single byte loopback
    bus_a.LEN0 = 4'd1;
    bus_a.TX_DATA0 = 8'hA5;
    exp_rx.push_back('{2'd0, 8'hA5});
    exp_done.push_back(2'd0);
    d0 = done_cnt; p0 = pop_cnt[0]; f0 = sck_falls;
    bus_a.REQ = 3'b001;
    wait_done_a(d0 + 1, 200);
    bus_a.REQ = 3'b000;
    repeat (12) @(posedge clk);
    chk("t1_cs_len", cs_last[0], 72);
    chk("t1_falls", sck_falls - f0, 8);
    chk("t1_sdi_bits", sdi_cap, 8'hA5);
    chk("t1_pops", pop_cnt[0] - p0, 1);
    chk("t1_dones", done_cnt - d0, 1);

    // round robin
    do_reset();
    bus_a.LEN0 = 4'd1; bus_a.LEN1 = 4'd1;
    bus_a.LEN2 = 4'd1;
    bus_a.TX_DATA0 = 8'h11; bus_a.TX_DATA1 = 8'h22;
    bus_a.TX_DATA2 = 8'h33;
    exp_rx.push_back('{2'd0, 8'h11});
    exp_rx.push_back('{2'd1, 8'h22});
    exp_rx.push_back('{2'd2, 8'h33});
    exp_rx.push_back('{2'd0, 8'h11});
    exp_done.push_back(2'd0);
    exp_done.push_back(2'd1);
    exp_done.push_back(2'd2);
    exp_done.push_back(2'd0);
    g0 = gnt_log.size(); gl0 = gap_log.size();
    d0 = done_cnt;
    bus_a.REQ = 3'b111;
    wait_done_a(d0 + 4, 600);
    bus_a.REQ = 3'b000;
    repeat (12) @(posedge clk);
    chk("rr_ngnt", gnt_log.size() - g0, 4);
    for (int i = 0; i < 4; i++) begin
      if (g0 + i < gnt_log.size())
        chk("rr_order", gnt_log[g0 + i],
            (i == 1) ? 3'b010 :
            (i == 2) ? 3'b100 : 3'b001);
    end
    mn = 1000000;
    for (int i = gl0; i < gap_log.size(); i++)
      if (gap_log[i] < mn) mn = gap_log[i];
    chk("rr_ngap", gap_log.size() - gl0, 4);
    chk("rr_gap_min", mn >= 9, 1);

    // length 0 means 16 bytes
    do_reset();
    bus_a.LEN1 = 4'd0;
    sdo_one = 1'b1;
    for (int i = 0; i < 16; i++)
      exp_rx.push_back('{2'd1, 8'hFF});
    exp_done.push_back(2'd1);
    d0 = done_cnt; p0 = pop_cnt[1]; r0 = rx_cnt[1];
    bus_a.REQ = 3'b010;
    wait_done_a(d0 + 1, 1300);
    bus_a.REQ = 3'b000;
    repeat (12) @(posedge clk);
    sdo_one = 1'b0;
    chk("l16_pops", pop_cnt[1] - p0, 16);
    chk("l16_rxv", rx_cnt[1] - r0, 16);
    chk("l16_cs_len", cs_last[1], 8 + 256 * 4);
    chk("l16_dones", done_cnt - d0, 1);

    // request drop mid transaction
    do_reset();
    bus_a.LEN2 = 4'd3;
    bus_a.TX_DATA2 = 8'h5A;
    for (int i = 0; i < 3; i++)
      exp_rx.push_back('{2'd2, 8'h5A});
    exp_done.push_back(2'd2);
    d0 = done_cnt; p0 = pop_cnt[2];
    bus_a.REQ = 3'b100;
    n = 0;
    while (pop_cnt[2] < p0 + 1 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("drop_first_pop", pop_cnt[2] - p0, 1);
    #1 bus_a.REQ = 3'b000;
    wait_done_a(d0 + 1, 400);
    repeat (12) @(posedge clk);
    chk("drop_pops", pop_cnt[2] - p0, 3);
    chk("drop_dones", done_cnt - d0, 1);

    // reset mid transfer; pointer must return to 0
    do_reset();
    bus_a.LEN0 = 4'd1;
    bus_a.TX_DATA0 = 8'h0F;
    exp_rx.push_back('{2'd0, 8'h0F});
    exp_done.push_back(2'd0);
    d0 = done_cnt;
    bus_a.REQ = 3'b001;
    wait_done_a(d0 + 1, 200);
    bus_a.REQ = 3'b000;
    bus_a.LEN1 = 4'd4;
    bus_a.TX_DATA1 = 8'hC3;
    exp_rx.push_back('{2'd1, 8'hC3});
    r0 = rx_cnt[1]; d0 = done_cnt;
    bus_a.REQ = 3'b010;
    n = 0;
    while (rx_cnt[1] < r0 + 1 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("mid_byte1", rx_cnt[1] - r0, 1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_cs", {cs_alt_a, cs_m_a, cs_ag_a}, 3'b111);
    chk("mid_sck", sck_a, 1);
    chk("mid_gnt", bus_a.GNT, 0);
    chk("mid_done", bus_a.DONE, 0);
    bus_a.REQ = 3'b011;
    repeat (3) @(posedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    #1 rst_n = 1'b1;
    n = 0;
    while (bus_a.GNT == 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_regrant", bus_a.GNT, 3'b001);
    bus_a.REQ = 3'b000;
    exp_rx.push_back('{2'd0, 8'h0F});
    exp_done.push_back(2'd0);
    wait_done_a(d0 + 1, 200);
    repeat (12) @(posedge clk);

    // CLK_DIV=1 corner on second instance
    bus_b.LEN0 = 4'd1;
    bus_b.TX_DATA0 = 8'h3C;
    exp_b.push_back('{2'd0, 8'h3C});
    d0 = b_done; r0 = b_rx;
    bus_b.REQ = 3'b001;
    n = 0;
    while (b_done < d0 + 1 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("b_done", b_done - d0, 1);
    #1 bus_b.REQ = 3'b000;
    repeat (12) @(posedge clk);
    chk("b_cs_len", b_last, 18);
    chk("b_sck_per", b_per, 2);
    chk("b_rx_cnt", b_rx - r0, 1);
    chk("b_cs_idle", {cs_alt_b, cs_m_b}, 2'b11);

    chk("sb_rx_left", exp_rx.size(), 0);
    chk("sb_done_left", exp_done.size(), 0);
    chk("sb_b_left", exp_b.size(), 0);
    chk("cs_multi_low", multi_low, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_sensor_arbiter.md
Name: spi_sensor_arbiter

Overview:
- Shares one SPI mode-3 master between three sensor requesters: accel/gyro (CS_AG), magnetometer (CS_M) and altimeter (CS_ALT).
- Arbitrates round-robin, drives the chip selects and SCK/SDI, samples SDO, and hands bytes to and from the granted requester.
- Sits between the sensor-polling logic inside the top entity and the board SPI pins.

Parameters:
- CLK_DIV, 4, SCK half-period in CLOCK cycles; legal range 1..255.
- GAP_CYCLES, 8, minimum CLOCK cycles all CS stay high between transactions; must be at least 1.

Ports:
- CLOCK  in  1  system clock; all logic on posedge.
- RESET_N  in  1  asynchronous reset, active-low.
- REQ  in  3  level request per requester; index 0=AG, 1=M, 2=ALT.
- LEN0, LEN1, LEN2  in  4 each  byte count per requester; 0 means 16 bytes.
- TX_DATA0, TX_DATA1, TX_DATA2  in  8 each  next byte to send from each requester.
- GNT  out  3  one-hot grant; held for the whole transaction.
- TX_POP  out  3  one-hot one-cycle pulse: the granted TX_DATAx was loaded this cycle.
- RX_DATA  out  8  last received byte.
- RX_VALID  out  3  one-hot one-cycle pulse: RX_DATA updated for that requester.
- DONE  out  3  one-hot one-cycle pulse: transaction finished.
- CS_AG, CS_M, CS_ALT  out  1 each  chip selects, active-low.
- SCK  out  1  SPI clock; idles high (CPOL=1, CPHA=1).
- SDI  out  1  MOSI, MSB first.
- SDO  in  1  MISO.

Behaviour:
- Reset: all outputs and state are asynchronously forced while RESET_N=0.
  - GNT, TX_POP, RX_VALID, DONE = 0; RX_DATA = 0; SDI = 0.
  - All CS = 1; SCK = 1; FSM = IDLE; round-robin pointer = 0.
  - This applies even mid-transfer; there is no partial completion and no DONE.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - When REQ is nonzero, select the first set bit at or after the pointer, wrapping 2 -> 0.
  - Next cycle: GNT set; matching CS low; LENx latched (0 -> 16); TX_POP pulses and TX_DATAx is loaded into the shift register.
  - Enter SETUP.
- SETUP: CLK_DIV cycles with CS low and SCK high; SDI = shift MSB.
- SHIFT: each bit is CLK_DIV cycles SCK low, then CLK_DIV cycles SCK high.
  - SDI changes only on SCK falling edges.
  - SDO is sampled on the cycle SCK rises.
  - Bits go MSB first; 8 bits per byte.
  - After the 8th rising edge:
    - Next cycle, RX_DATA = assembled byte and RX_VALID[g] pulses.
    - If more bytes remain: TX_POP[g] pulses and the next TX_DATAx is loaded in that same cycle; the next byte's first falling edge follows with no extra gap.
    - Otherwise go to HOLD.
- HOLD: CLK_DIV cycles with SCK high and CS low; then CS high, DONE[g] pulses, GNT cleared, pointer = g+1 mod 3.
- GAP: GAP_CYCLES cycles with all CS high; REQ is ignored; then IDLE.
- Mid-transfer request changes:
  - A REQ drop during a transaction is ignored; the latched length completes.
  - LEN and TX_DATA of non-granted requesters are ignored.
- A requester holding REQ after its DONE is served again only after the others, per the round-robin pointer.
- At most one CS is low at any time; CS_x is low only while GNT[x]=1.
- Transaction duration, first CS low to CS high:
  - CLK_DIV + N*16*CLK_DIV + CLK_DIV cycles, where N = bytes.
  - An RX_VALID cycle is the first cycle of the next byte's SCK-low phase, so it does not stretch the transaction.

Test Plan:
- Single byte loopback:
  - Stimulus: CLK_DIV=4; REQ=001; LEN0=1; TX_DATA0=0xA5; SDO tied to SDI.
  - Response: CS_AG low for exactly 72 cycles; 8 SCK falling edges; SDI bits 1,0,1,0,0,1,0,1; RX_DATA=0xA5 with RX_VALID=001; DONE=001 once; TX_POP=001 once.
- Round-robin:
  - Stimulus: REQ=111 held, all LEN=1.
  - Response: grants in order 001, 010, 100, 001; each CS-high gap is at least GAP_CYCLES+1 cycles; never two CS low at once.
- Length 0 means 16 bytes:
  - Stimulus: LEN1=0; SDO=1.
  - Response: 16 TX_POP and 16 RX_VALID pulses on index 1; every RX_DATA=0xFF; one DONE=010; CS_M low for 8+256*4 cycles.
- Request drop:
  - Stimulus: REQ=100 with LEN2=3; deassert REQ after the first TX_POP.
  - Response: all 3 bytes transfer; then DONE=100.
- Reset mid-transfer:
  - Stimulus: pull RESET_N low during byte 2 of a 4-byte transfer.
  - Response: immediately all CS=1, SCK=1, GNT=0 with no DONE; after release with REQ=011, grant goes to 001 (pointer reset to 0).
- CLK_DIV=1 corner:
  - Stimulus: CLK_DIV=1; single byte 0x3C in loopback.
  - Response: SCK period 2 cycles; RX_DATA=0x3C; CS low 18 cycles.
